// File: rtl/semaforo_fsm.sv
// semaforo_fsm: clocked two-road traffic-light controller.
// Road requests A/B select which road gets green. Each green lasts at least
// T_GREEN_MIN cycles and at most T_GREEN_MAX cycles under contention. It is
// followed by a fixed yellow and an all-red clearance before the other road
// may go green. As/Bs mirror the green lamps so legacy consumers of the old
// combinational grant block keep working.
// Optional build macro: SEMAFORO_NOTURNO_EN adds the `noturno` input. That
// input forces a night-mode state (PISCA) in which both yellows blink.
module semaforo_fsm #(
  parameter int CNT_W       = 8,
  parameter int T_GREEN_MIN = 4,
  parameter int T_GREEN_MAX = 10,
  parameter int T_YELLOW    = 2,
  parameter int T_ALL_RED   = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       A,
  input  logic       B,
`ifdef SEMAFORO_NOTURNO_EN
  input  logic       noturno,
`endif
  output logic [2:0] luz_a,
  output logic [2:0] luz_b,
  output logic       As,
  output logic       Bs
);

  // Lamp encodings {red, yellow, green}
  localparam logic [2:0] LUZ_VERM  = 3'b100;
  localparam logic [2:0] LUZ_AMAR  = 3'b010;
  localparam logic [2:0] LUZ_VERDE = 3'b001;
`ifdef SEMAFORO_NOTURNO_EN
  localparam logic [2:0] LUZ_OFF   = 3'b000;
`endif

  // Timer value seen at the edge on which each phase expires
  localparam logic [CNT_W-1:0] GMIN_LAST    = CNT_W'(T_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST    = CNT_W'(T_GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST  = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] ALL_RED_LAST = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] TIMER_SAT    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] TIMER_ONE    = CNT_W'(1'b1);

`ifdef SEMAFORO_NOTURNO_EN
  typedef enum logic [2:0] {
    VERM_BA = 3'd0,
    A_VERDE = 3'd1,
    A_AMAR  = 3'd2,
    VERM_AB = 3'd3,
    B_VERDE = 3'd4,
    B_AMAR  = 3'd5,
    PISCA   = 3'd6
  } state_e;
`else
  typedef enum logic [2:0] {
    VERM_BA = 3'd0,
    A_VERDE = 3'd1,
    A_AMAR  = 3'd2,
    VERM_AB = 3'd3,
    B_VERDE = 3'd4,
    B_AMAR  = 3'd5
  } state_e;
`endif

  state_e           state_q;
  state_e           state_d;
  state_e           state_seq_s;
  logic [CNT_W-1:0] timer_q;
  logic [CNT_W-1:0] timer_d;
  logic [2:0]       luz_a_q;
  logic [2:0]       luz_a_d;
  logic [2:0]       luz_b_q;
  logic [2:0]       luz_b_d;
`ifdef SEMAFORO_NOTURNO_EN
  logic             blink_q;
  logic             blink_d;
`endif

  // A green road yields once minimum green has elapsed and the other road
  // is waiting. If its own road still requests, it yields only at max green.
  function automatic logic green_yields(input logic [CNT_W-1:0] t,
                                        input logic own_req,
                                        input logic other_req);
    return (t >= GMIN_LAST) && other_req && (!own_req || (t >= GMAX_LAST));
  endfunction

  // Steady lamp pattern for each state as {luz_a, luz_b}
  function automatic logic [5:0] lamps_of(input state_e s);
    logic [5:0] l;
    case (s)
      A_VERDE: l = {LUZ_VERDE, LUZ_VERM};
      A_AMAR:  l = {LUZ_AMAR,  LUZ_VERM};
      B_VERDE: l = {LUZ_VERM,  LUZ_VERDE};
      B_AMAR:  l = {LUZ_VERM,  LUZ_AMAR};
      VERM_BA: l = {LUZ_VERM,  LUZ_VERM};
      VERM_AB: l = {LUZ_VERM,  LUZ_VERM};
      default: l = {LUZ_VERM,  LUZ_VERM};
    endcase
    return l;
  endfunction

  // Normal day-time phase sequencing from timer and road requests
  always_comb begin
    state_seq_s = state_q;
    case (state_q)
      VERM_BA: begin
        if (timer_q == ALL_RED_LAST) state_seq_s = A_VERDE;
        else                         state_seq_s = VERM_BA;
      end
      A_VERDE: begin
        if (green_yields(timer_q, A, B)) state_seq_s = A_AMAR;
        else                             state_seq_s = A_VERDE;
      end
      A_AMAR: begin
        if (timer_q == YELLOW_LAST) state_seq_s = VERM_AB;
        else                        state_seq_s = A_AMAR;
      end
      VERM_AB: begin
        if (timer_q == ALL_RED_LAST) state_seq_s = B_VERDE;
        else                         state_seq_s = VERM_AB;
      end
      B_VERDE: begin
        if (green_yields(timer_q, B, A)) state_seq_s = B_AMAR;
        else                             state_seq_s = B_VERDE;
      end
      B_AMAR: begin
        if (timer_q == YELLOW_LAST) state_seq_s = VERM_BA;
        else                        state_seq_s = B_AMAR;
      end
      // Night mode (or any illegal code) restarts from the clearance before A
      default: state_seq_s = VERM_BA;
    endcase
  end

  // Night mode overrides the normal sequence while it is requested
  always_comb begin
`ifdef SEMAFORO_NOTURNO_EN
    if (noturno) state_d = PISCA;
    else         state_d = state_seq_s;
`else
    state_d = state_seq_s;
`endif
  end

  // Phase timer: restarts on every state change, otherwise counts and saturates
  always_comb begin
    if (state_d != state_q)      timer_d = {CNT_W{1'b0}};
    else if (timer_q == TIMER_SAT) timer_d = timer_q;
    else                         timer_d = timer_q + TIMER_ONE;
  end

`ifdef SEMAFORO_NOTURNO_EN
  // Blink phase: lit on entry to night mode, then toggles every cycle
  always_comb begin
    if (state_q == PISCA) blink_d = ~blink_q;
    else                  blink_d = 1'b1;
  end
`endif

  // Lamp decode of the next state so the lamp flops track the state flop
  always_comb begin
`ifdef SEMAFORO_NOTURNO_EN
    if (state_d == PISCA) begin
      if (blink_d) {luz_a_d, luz_b_d} = {LUZ_AMAR, LUZ_AMAR};
      else         {luz_a_d, luz_b_d} = {LUZ_OFF, LUZ_OFF};
    end else begin
      {luz_a_d, luz_b_d} = lamps_of(state_d);
    end
`else
    {luz_a_d, luz_b_d} = lamps_of(state_d);
`endif
  end

  // State, timer and lamp registers; reset forces all-red before road A
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= VERM_BA;
      timer_q <= {CNT_W{1'b0}};
      luz_a_q <= LUZ_VERM;
      luz_b_q <= LUZ_VERM;
`ifdef SEMAFORO_NOTURNO_EN
      blink_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      luz_a_q <= luz_a_d;
      luz_b_q <= luz_b_d;
`ifdef SEMAFORO_NOTURNO_EN
      blink_q <= blink_d;
`endif
    end
  end

  assign luz_a = luz_a_q;
  assign luz_b = luz_b_q;
  assign As    = luz_a_q[0];
  assign Bs    = luz_b_q[0];

endmodule

// File: tb/tb_semaforo_fsm.sv
// tb_semaforo_fsm: directed and randomized checks of semaforo_fsm. The
// expected values come from a phase/duration model and from fixed timing
// constants.
module tb_semaforo_fsm;

  localparam int T_GREEN_MIN = 4;
  localparam int T_GREEN_MAX = 10;
  localparam int T_YELLOW    = 2;
  localparam int T_ALL_RED   = 1;

  localparam int PH_CLEAR  = 0;
  localparam int PH_GREEN  = 1;
  localparam int PH_YELLOW = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       A     = 1'b0;
  logic       B     = 1'b0;
  logic [2:0] luz_a;
  logic [2:0] luz_b;
  logic       As;
  logic       Bs;
`ifdef SEMAFORO_NOTURNO_EN
  logic       noturno = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model: which road owns the current (or upcoming) green,
  // which phase is active, and how many cycles that phase has completed.
  int m_road;
  int m_phase;
  int m_cycles;

  semaforo_fsm #(
    .CNT_W(8), .T_GREEN_MIN(T_GREEN_MIN), .T_GREEN_MAX(T_GREEN_MAX),
    .T_YELLOW(T_YELLOW), .T_ALL_RED(T_ALL_RED)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .A(A),
    .B(B),
`ifdef SEMAFORO_NOTURNO_EN
    .noturno(noturno),
`endif
    .luz_a(luz_a),
    .luz_b(luz_b),
    .As(As),
    .Bs(Bs)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, want);
    end
  endtask

  task automatic model_reset();
    m_road   = 0;
    m_phase  = PH_CLEAR;
    m_cycles = 0;
  endtask

  // Advance the model by one clock using the request levels seen at that edge
  task automatic model_step(input bit a_in, input bit b_in);
    bit own;
    bit other;
    int done;
    own   = (m_road == 0) ? a_in : b_in;
    other = (m_road == 0) ? b_in : a_in;
    done  = m_cycles + 1;
    case (m_phase)
      PH_CLEAR: begin
        if (done >= T_ALL_RED) begin m_phase = PH_GREEN; m_cycles = 0; end
        else m_cycles = done;
      end
      PH_GREEN: begin
        if (other && done >= T_GREEN_MIN && (!own || done >= T_GREEN_MAX)) begin
          m_phase = PH_YELLOW; m_cycles = 0;
        end else m_cycles = done;
      end
      default: begin
        if (done >= T_YELLOW) begin
          m_phase = PH_CLEAR; m_road = 1 - m_road; m_cycles = 0;
        end else m_cycles = done;
      end
    endcase
  endtask

  function automatic logic [2:0] exp_lamp(input int road);
    if (m_road != road)         return 3'b100;
    if (m_phase == PH_GREEN)    return 3'b001;
    if (m_phase == PH_YELLOW)   return 3'b010;
    return 3'b100;
  endfunction

  task automatic check_model(input string tag);
    logic [2:0] ea;
    logic [2:0] eb;
    ea = exp_lamp(0);
    eb = exp_lamp(1);
    chk({tag, "_luz_a"}, luz_a, ea);
    chk({tag, "_luz_b"}, luz_b, eb);
    chk({tag, "_As"}, {2'b00, As}, {2'b00, ea[0]});
    chk({tag, "_Bs"}, {2'b00, Bs}, {2'b00, eb[0]});
  endtask

  // One clock with the given requests; outputs are then sampled 1 after the edge
  task automatic tick(input bit a_in, input bit b_in);
    A = a_in;
    B = b_in;
    @(posedge clk);
    model_step(a_in, b_in);
    #1;
  endtask

  // Assert reset away from any clock edge, check the lamps drop at once, release
  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_luz_a", luz_a, 3'b100);
    chk("rst_async_luz_b", luz_b, 3'b100);
    chk("rst_async_AsBs", {1'b0, As, Bs}, 3'b000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Safety: at most one road may show a non-red lamp in any cycle
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      assert (luz_a == 3'b100 || luz_b == 3'b100) else begin
        errors++;
        $error("FAIL overlap observed luz_a=%b luz_b=%b expected one road red", luz_a, luz_b);
      end
    end
  end

  initial begin
    bit a_r;
    bit b_r;
    int p;

    // No requests: A goes green on the first edge and holds
    do_reset();
    tick(1'b0, 1'b0);
    chk("idle_first_As", {1'b0, As, Bs}, 3'b010);
    for (int i = 0; i < 49; i++) begin
      tick(1'b0, 1'b0);
      chk("idle_luz_b", luz_b, 3'b100);
      check_model("idle");
    end
    // Long green with saturated timer, then B arrives: immediate yield
    for (int i = 0; i < 260; i++) begin
      tick(1'b1, 1'b0);
      check_model("sat");
    end
    tick(1'b1, 1'b1);
    chk("sat_yield_luz_a", luz_a, 3'b010);

    // Only B requests from reset
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      tick(1'b0, 1'b1);
      check_model("bonly");
      if (k <= 4)      chk("bonly_green_a", luz_a, 3'b001);
      else if (k <= 6) chk("bonly_yellow_a", luz_a, 3'b010);
      else if (k == 7) chk("bonly_clear", {luz_a[2], luz_b[2], 1'b0}, 3'b110);
      else             chk("bonly_Bs", {2'b00, Bs}, 3'b001);
    end

    // Both request constantly: fixed 26-cycle rotation
    do_reset();
    for (int k = 1; k <= 52; k++) begin
      tick(1'b1, 1'b1);
      check_model("both");
      p = (k - 1) % 26;
      chk("both_As", {2'b00, As}, {2'b00, (p < 10) ? 1'b1 : 1'b0});
      chk("both_Bs", {2'b00, Bs}, {2'b00, (p >= 13 && p <= 22) ? 1'b1 : 1'b0});
      if (p == 10 || p == 11) chk("both_yellow_a", luz_a, 3'b010);
      if (p == 23 || p == 24) chk("both_yellow_b", luz_b, 3'b010);
    end

    // B green: a one-cycle A pulse before min green does not cause a yield
    do_reset();
    for (int k = 0; k < 8; k++) tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);
    for (int k = 0; k < 15; k++) begin
      tick(1'b0, 1'b1);
      chk("pulse_Bs", {2'b00, Bs}, 3'b001);
    end

    // B green: A held from timer=1 forces yellow at max green
    do_reset();
    for (int k = 0; k < 8; k++) tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, 1'b1);
      chk("hold_Bs", {2'b00, Bs}, 3'b001);
    end
    tick(1'b1, 1'b1);
    chk("hold_max_luz_b", luz_b, 3'b010);

    // Reset in the middle of A yellow
    do_reset();
    for (int k = 0; k < 5; k++) tick(1'b0, 1'b1);
    chk("mid_amar_luz_a", luz_a, 3'b010);
    do_reset();
    tick(1'b0, 1'b1);
    chk("restart_As", {2'b00, As}, 3'b001);

    // Randomized requests with occasional resets
    do_reset();
    a_r = 1'b0;
    b_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) a_r = ~a_r;
      if ($urandom_range(0, 5) == 0) b_r = ~b_r;
      if ($urandom_range(0, 149) == 0) do_reset();
      tick(a_r, b_r);
      check_model("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
